// File: rtl/bbox_outline_writer_if.sv
// bbox_outline_writer_if
// Ready/valid pixel write port between the outline writer and the frame RAM.
//   wr_en    : write valid, driven by the writer
//   wr_addr  : pixel address (y*IMG_W + x)
//   wr_data  : pixel value (RGB888 by default)
//   wr_ready : RAM accepts the write this cycle
// The master modport is the writer side; the slave modport is the RAM side.
interface bbox_outline_writer_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 24
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/bbox_outline_writer.sv
// bbox_outline_writer
// Draws the 1-pixel border of a bounding box into the frame RAM, one pixel
// write per accepted cycle, in the order top row, bottom row, left column,
// right column. Corners and colour are latched when start is taken in IDLE.
//   CLOCK_50       : clock, rising edge
//   reset          : synchronous, active-high
//   start          : one-cycle request, only looked at in IDLE
//   xmin/xmax      : inclusive x bounds
//   ymin/ymax      : inclusive y bounds
//   color          : outline colour
//   busy           : high while border writes are being issued
//   done           : one-cycle completion pulse
//   err            : one-cycle pulse with done when the box was invalid
//   wr             : ready/valid write port (master side)
module bbox_outline_writer #(
  parameter int IMG_W  = 768,
  parameter int IMG_H  = 512,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 24
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [XW-1:0]           xmin,
  input  logic [XW-1:0]           xmax,
  input  logic [YW-1:0]           ymin,
  input  logic [YW-1:0]           ymax,
  input  logic [PIX_W-1:0]        color,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  bbox_outline_writer_if.master   wr
);

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    BOTTOM,
    LEFT,
    RIGHT,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  state_t            state, state_nxt;
  logic [XW-1:0]     xmin_q, xmin_nxt;
  logic [XW-1:0]     xmax_q, xmax_nxt;
  logic [YW-1:0]     ymin_q, ymin_nxt;
  logic [YW-1:0]     ymax_q, ymax_nxt;
  logic [PIX_W-1:0]  color_q, color_nxt;
  logic              err_q, err_nxt;
  logic [XW-1:0]     x_cur, x_nxt;
  logic [YW-1:0]     y_cur, y_nxt;
  logic [ADDR_W-1:0] row_base, row_base_nxt;
  logic [ADDR_W-1:0] row_min, row_min_nxt;
  logic [ADDR_W-1:0] row_max, row_max_nxt;

  logic              writing;
  logic              accept;
  logic              box_bad;
  logic              x_last;
  logic              y_last;
  logic              single_row;
  logic              single_col;
  logic              has_sides;
  logic [ADDR_W-1:0] start_row_min;
  logic [ADDR_W-1:0] start_row_max;

  // Box checks on the raw inputs (used only when start is taken) and
  // end-of-run conditions on the latched corners.
  always_comb begin
    box_bad       = (xmin > xmax) || (ymin > ymax) ||
                    (int'(xmax) >= IMG_W) || (int'(ymax) >= IMG_H);
    // Constant multiplies: the only place a row base is formed from a y value.
    start_row_min = ADDR_W'(ymin) * ROW_STEP;
    start_row_max = ADDR_W'(ymax) * ROW_STEP;
    writing       = (state == TOP) || (state == BOTTOM) ||
                    (state == LEFT) || (state == RIGHT);
    accept        = writing && wr.wr_ready;
    x_last        = (x_cur == xmax_q);
    // Side columns stop one row above the bottom edge.
    y_last        = (y_cur == (ymax_q - YW'(1)));
    single_row    = (ymax_q == ymin_q);
    single_col    = (xmax_q == xmin_q);
    has_sides     = ((ymax_q - ymin_q) >= YW'(2));
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      color_q  <= '0;
      err_q    <= 1'b0;
      x_cur    <= '0;
      y_cur    <= '0;
      row_base <= '0;
      row_min  <= '0;
      row_max  <= '0;
    end else begin
      state    <= state_nxt;
      xmin_q   <= xmin_nxt;
      xmax_q   <= xmax_nxt;
      ymin_q   <= ymin_nxt;
      ymax_q   <= ymax_nxt;
      color_q  <= color_nxt;
      err_q    <= err_nxt;
      x_cur    <= x_nxt;
      y_cur    <= y_nxt;
      row_base <= row_base_nxt;
      row_min  <= row_min_nxt;
      row_max  <= row_max_nxt;
    end
  end

  // Next-state logic. Every edge transition happens on the accepting edge and
  // loads the first pixel of the next edge directly, so there is no bubble.
  always_comb begin
    state_nxt    = state;
    xmin_nxt     = xmin_q;
    xmax_nxt     = xmax_q;
    ymin_nxt     = ymin_q;
    ymax_nxt     = ymax_q;
    color_nxt    = color_q;
    err_nxt      = err_q;
    x_nxt        = x_cur;
    y_nxt        = y_cur;
    row_base_nxt = row_base;
    row_min_nxt  = row_min;
    row_max_nxt  = row_max;

    case (state)
      IDLE: begin
        if (start) begin
          color_nxt = color;
          xmin_nxt  = xmin;
          xmax_nxt  = xmax;
          ymin_nxt  = ymin;
          ymax_nxt  = ymax;
          if (box_bad) begin
            err_nxt   = 1'b1;
            state_nxt = FIN;
          end else begin
            err_nxt      = 1'b0;
            state_nxt    = TOP;
            x_nxt        = xmin;
            y_nxt        = ymin;
            row_base_nxt = start_row_min;
            row_min_nxt  = start_row_min;
            row_max_nxt  = start_row_max;
          end
        end
      end

      TOP: begin
        if (accept) begin
          if (!x_last) begin
            x_nxt = x_cur + XW'(1);
          end else if (single_row) begin
            state_nxt = FIN;
          end else begin
            state_nxt    = BOTTOM;
            x_nxt        = xmin_q;
            row_base_nxt = row_max;
          end
        end
      end

      BOTTOM: begin
        if (accept) begin
          if (!x_last) begin
            x_nxt = x_cur + XW'(1);
          end else if (has_sides) begin
            state_nxt    = LEFT;
            x_nxt        = xmin_q;
            y_nxt        = ymin_q + YW'(1);
            row_base_nxt = row_min + ROW_STEP;
          end else begin
            state_nxt = FIN;
          end
        end
      end

      LEFT: begin
        if (accept) begin
          if (!y_last) begin
            y_nxt        = y_cur + YW'(1);
            row_base_nxt = row_base + ROW_STEP;
          end else if (!single_col) begin
            // A one-pixel-wide box has its right column already drawn as left.
            state_nxt    = RIGHT;
            x_nxt        = xmax_q;
            y_nxt        = ymin_q + YW'(1);
            row_base_nxt = row_min + ROW_STEP;
          end else begin
            state_nxt = FIN;
          end
        end
      end

      RIGHT: begin
        if (accept) begin
          if (!y_last) begin
            y_nxt        = y_cur + YW'(1);
            row_base_nxt = row_base + ROW_STEP;
          end else begin
            state_nxt = FIN;
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
        err_nxt   = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from state so reset clears them on the next edge.
  always_comb begin
    wr.wr_en   = writing;
    wr.wr_addr = row_base + ADDR_W'(x_cur);
    wr.wr_data = color_q;
    busy       = writing;
    done       = (state == FIN);
    err        = (state == FIN) && err_q;
  end

endmodule

// File: tb/tb_bbox_outline_writer.sv
// tb_bbox_outline_writer
// Drives directed and random boxes into bbox_outline_writer on an 8x8 image
// and compares the accepted write stream, done/err timing, busy and
// backpressure behaviour against a border-list model built from box rules.
module tb_bbox_outline_writer;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int XW     = 4;
  localparam int YW     = 4;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 24;
  localparam int BUDGET = 200;

  logic             CLOCK_50 = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic [XW-1:0]    xmin     = '0;
  logic [XW-1:0]    xmax     = '0;
  logic [YW-1:0]    ymin     = '0;
  logic [YW-1:0]    ymax     = '0;
  logic [PIX_W-1:0] color    = '0;
  logic             busy;
  logic             done;
  logic             err;

  bbox_outline_writer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) wr_port ();

  bbox_outline_writer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW),
    .ADDR_W(ADDR_W),
    .PIX_W (PIX_W)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .start   (start),
    .xmin    (xmin),
    .xmax    (xmax),
    .ymin    (ymin),
    .ymax    (ymax),
    .color   (color),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .wr      (wr_port)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Border pixels in drawing order, straight from the box rules.
  function automatic void buildExpected(input int x0, input int x1,
                                        input int y0, input int y1);
    expQ.delete();
    if (x0 > x1 || y0 > y1 || x1 >= IMG_W || y1 >= IMG_H) return;
    for (int x = x0; x <= x1; x++) expQ.push_back(y0 * IMG_W + x);
    if (y1 != y0)
      for (int x = x0; x <= x1; x++) expQ.push_back(y1 * IMG_W + x);
    for (int y = y0 + 1; y <= y1 - 1; y++) expQ.push_back(y * IMG_W + x0);
    if (x1 != x0)
      for (int y = y0 + 1; y <= y1 - 1; y++) expQ.push_back(y * IMG_W + x1);
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"},   32'(wr_port.wr_en),   32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_port.wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_port.wr_data), 32'd0);
    checkOutput({tag, "_busy"},    32'(busy),            32'd0);
    checkOutput({tag, "_done"},    32'(done),            32'd0);
    checkOutput({tag, "_err"},     32'(err),             32'd0);
  endtask

  // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                               input logic [PIX_W-1:0] col, input int readyMode,
                               input int resetAfter, input bit midStart,
                               input bit startAtDone);
    int cycle, got, lastAcc, doneCycle, holdBad, busyBad, dataBad, extra;
    bit invalid, stalled, r;
    logic [ADDR_W-1:0] prevAddr;
    logic [PIX_W-1:0]  prevData;

    buildExpected(x0, x1, y0, y1);
    invalid   = (x0 > x1 || y0 > y1 || x1 >= IMG_W || y1 >= IMG_H);
    cycle     = 1;
    got       = 0;
    lastAcc   = 0;
    doneCycle = 0;
    holdBad   = 0;
    busyBad   = 0;
    dataBad   = 0;
    extra     = 0;
    stalled   = 1'b0;
    prevAddr  = '0;
    prevData  = '0;

    xmin  = x0[XW-1:0];
    xmax  = x1[XW-1:0];
    ymin  = y0[YW-1:0];
    ymax  = y1[YW-1:0];
    color = col;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;

    while (doneCycle == 0 && cycle <= BUDGET) begin
      start = 1'b0;
      if (resetAfter > 0 && got == resetAfter) begin
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        checkResetOutputs("mid_reset");
        reset = 1'b0;
        return;
      end

      case (readyMode)
        0:       r = 1'b1;
        1:       r = (cycle % 3 == 1);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      wr_port.wr_ready = r;

      if (stalled && (wr_port.wr_en !== 1'b1 || wr_port.wr_addr !== prevAddr ||
                      wr_port.wr_data !== prevData))
        holdBad++;

      if (done === 1'b1) begin
        doneCycle = cycle;
      end else begin
        if (busy !== !invalid) busyBad++;
        if (wr_port.wr_en === 1'b1 && r) begin
          if (got < expQ.size())
            checkOutput($sformatf("addr[%0d]", got), 32'(wr_port.wr_addr), expQ[got]);
          else
            extra++;
          if (wr_port.wr_data !== col) dataBad++;
          got++;
          lastAcc = cycle;
        end
        stalled  = (wr_port.wr_en === 1'b1) && !r;
        prevAddr = wr_port.wr_addr;
        prevData = wr_port.wr_data;
        if (midStart && cycle == 3) begin
          xmin  = '0;
          xmax  = XW'(IMG_W - 1);
          ymin  = '0;
          ymax  = YW'(IMG_H - 1);
          start = 1'b1;
        end
        @(posedge CLOCK_50); #1;
        cycle++;
      end
    end

    if (doneCycle == 0) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
      return;
    end

    checkOutput("write_count", got, expQ.size());
    checkOutput("extra_writes", extra, 0);
    checkOutput("err_at_done", 32'(err), 32'(invalid));
    checkOutput("wr_en_at_done", 32'(wr_port.wr_en), 32'd0);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("data_bad", dataBad, 0);
    checkOutput("hold_bad", holdBad, 0);
    checkOutput("busy_bad", busyBad, 0);
    if (readyMode == 0 || invalid)
      checkOutput("done_cycle", doneCycle, expQ.size() + 1);
    else
      checkOutput("done_after_last", doneCycle, lastAcc + 1);

    if (startAtDone) begin
      xmin  = '0;
      xmax  = XW'(1);
      ymin  = '0;
      ymax  = YW'(1);
      start = 1'b1;
    end
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("wr_en_after_done", 32'(wr_port.wr_en), 32'd0);
  endtask

  initial begin
    int x0, x1, y0, y1, mode;

    wr_port.wr_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0;
    @(posedge CLOCK_50); #1;

    $display("[TB] directed boxes");
    applyStimulus(2, 5, 3, 6, 24'hABCDEF, 0, 0, 1'b0, 1'b0);
    applyStimulus(4, 4, 4, 4, 24'h123456, 0, 0, 1'b0, 1'b0);
    applyStimulus(1, 6, 2, 2, 24'h00FF00, 0, 0, 1'b0, 1'b0);
    applyStimulus(3, 3, 0, 3, 24'hFF0000, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 7, 0, 7, 24'h0000FF, 0, 0, 1'b0, 1'b0);

    $display("[TB] invalid boxes");
    applyStimulus(5, 2, 0, 3, 24'h111111, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 8, 0, 3, 24'h222222, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 3, 0, 8, 24'h333333, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 3, 4, 2, 24'h444444, 0, 0, 1'b0, 1'b0);

    $display("[TB] backpressure, ignored starts, reset");
    applyStimulus(2, 5, 3, 6, 24'h5A5A5A, 1, 0, 1'b1, 1'b1);
    applyStimulus(2, 5, 3, 6, 24'hC0FFEE, 0, 5, 1'b0, 1'b0);
    applyStimulus(2, 5, 3, 6, 24'hBEEF01, 0, 0, 1'b0, 1'b0);

    $display("[TB] random boxes");
    for (int i = 0; i < 30; i++) begin
      x0   = $urandom_range(0, 9);
      x1   = $urandom_range(0, 9);
      y0   = $urandom_range(0, 9);
      y1   = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      applyStimulus(x0, x1, y0, y1, PIX_W'($urandom), mode, 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
